// File: rtl/param_readback.sv
// param_readback
//
// Reader side of the parameter registry. On a readback request the current
// CAN acceptance mask, acceptance code and SJW are snapshotted. They are then
// streamed to the host/debug port as a header-prefixed byte frame over a
// valid/ready byte handshake.
//
// Frame: HDR_BYTE, B0, B1, B2 [, CSUM]
//   S    = {mask[10:0], code[10:0], sjw[1:0]}
//   B0   = S[23:16], B1 = S[15:8], B2 = S[7:0]
//   CSUM = HDR_BYTE ^ B0 ^ B1 ^ B2   (only when PARAM_RB_CSUM_EN is defined)
//
// Optional feature macro: PARAM_RB_CSUM_EN (appends the CSUM byte).
//
// Parameters:
//   HDR_BYTE    first byte of every frame
//   GAP_CYCLES  idle cycles after each accepted byte before the next (0..15)
//
// Ports:
//   clk         system clock, rising edge
//   reset       synchronous active-low reset
//   mask_param  acceptance mask from the registry (11b)
//   code_param  acceptance code from the registry (11b)
//   sjw         synchronization jump width from the registry (2b)
//   rd_req      single-cycle request to start a frame (ignored while busy)
//   tx_data     byte offered downstream (8'h00 when not valid)
//   tx_valid    tx_data is valid
//   tx_ready    downstream accepts the byte
//   busy        frame in progress
//   done        one-cycle pulse when the frame completes
//
// state | meaning
// ------+---------------------------------------------------------------
// IDLE  | waiting for rd_req; byte index held at 0
// SEND  | tx_valid high, byte at idx offered until tx_ready
// GAP   | tx_valid low for GAP_CYCLES cycles between bytes
// FIN   | done pulse, busy low; returns to IDLE

module param_readback #(
    parameter logic [7:0] HDR_BYTE   = 8'hA5,
    parameter int         GAP_CYCLES = 0
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [10:0] mask_param,
    input  logic [10:0] code_param,
    input  logic [1:0]  sjw,
    input  logic        rd_req,
    output logic [7:0]  tx_data,
    output logic        tx_valid,
    input  logic        tx_ready,
    output logic        busy,
    output logic        done
);

    typedef enum logic [1:0] {IDLE, SEND, GAP, FIN} state_t;

    // Gap counter is a down-counter loaded with GAP_CYCLES-1 so that the
    // terminal compare at zero yields exactly GAP_CYCLES idle cycles.
    localparam logic [3:0] GAP_LOAD = (GAP_CYCLES > 0) ? 4'(GAP_CYCLES - 1) : 4'd0;

`ifdef PARAM_RB_CSUM_EN
    localparam logic [2:0] LAST_IDX = 3'd4;
`else
    localparam logic [2:0] LAST_IDX = 3'd3;
`endif

    state_t      state;
    logic [23:0] snap;
    logic [2:0]  idx;
    logic [3:0]  gap_cnt;
    logic [2:0]  idx_next;
    logic [2:0]  sel_idx;
    logic [7:0]  sel_byte;

`ifdef PARAM_RB_CSUM_EN
    logic [7:0] csum;
    assign csum = HDR_BYTE ^ snap[23:16] ^ snap[15:8] ^ snap[7:0];
`endif

    assign idx_next = idx + 3'd1;

    // In SEND the byte to load is the one after the current transfer; in GAP
    // idx was already advanced at the transfer, so it points at the next byte.
    assign sel_idx = (state == GAP) ? idx : idx_next;

    always_comb begin
        sel_byte = 8'h00;
        case (sel_idx)
            3'd0:    sel_byte = HDR_BYTE;
            3'd1:    sel_byte = snap[23:16];
            3'd2:    sel_byte = snap[15:8];
            3'd3:    sel_byte = snap[7:0];
`ifdef PARAM_RB_CSUM_EN
            3'd4:    sel_byte = csum;
`endif
            default: sel_byte = 8'h00;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state    <= IDLE;
            snap     <= 24'h000000;
            idx      <= 3'd0;
            gap_cnt  <= 4'd0;
            tx_data  <= 8'h00;
            tx_valid <= 1'b0;
            busy     <= 1'b0;
            done     <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    idx <= 3'd0;
                    if (rd_req) begin
                        snap     <= {mask_param, code_param, sjw};
                        state    <= SEND;
                        tx_valid <= 1'b1;
                        tx_data  <= HDR_BYTE;
                        busy     <= 1'b1;
                    end
                end
                SEND: begin
                    if (tx_valid && tx_ready) begin
                        if (idx == LAST_IDX) begin
                            state    <= FIN;
                            tx_valid <= 1'b0;
                            tx_data  <= 8'h00;
                            busy     <= 1'b0;
                            done     <= 1'b1;
                        end else begin
                            idx <= idx_next;
                            if (GAP_CYCLES > 0) begin
                                state    <= GAP;
                                tx_valid <= 1'b0;
                                tx_data  <= 8'h00;
                                gap_cnt  <= GAP_LOAD;
                            end else begin
                                tx_data <= sel_byte;
                            end
                        end
                    end
                end
                GAP: begin
                    if (gap_cnt == 4'd0) begin
                        state    <= SEND;
                        tx_valid <= 1'b1;
                        tx_data  <= sel_byte;
                    end else begin
                        gap_cnt <= gap_cnt - 4'd1;
                    end
                end
                FIN: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule
